// File: rtl/lc3_mem_pkg.sv
// Shared constants for the LC-3 memory access controller: FSM state encoding
// and default timing / MMIO address parameters.
package lc3_mem_pkg;

  localparam int unsigned WAIT_CYCLES_DEF = 3;
  localparam logic [15:0] MMIO_ADDR_DEF   = 16'hFFFF;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_ACCESS = 2'd1;
  localparam state_t ST_DONE   = 2'd2;

endpackage

// File: rtl/mem_access_ctrl_mmio_port.sv
// Memory-mapped I/O word: hex display register (write side) and switch
// input mux (read side). Only instantiated when MEM_MMIO_EN is defined.
module mmio_port
  import lc3_mem_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic        wr_en,
  input  logic [15:0] wr_data,
  input  logic        rd_en,
  input  logic [15:0] switches,
  output logic [15:0] rd_data,
  output logic [15:0] hex_reg
);

  logic [15:0] hex_d;
  logic [15:0] hex_q;

  // Next value of the hex display register and the switch read mux.
  always_comb begin
    hex_d   = hex_q;
    rd_data = 16'h0000;
    if (wr_en) begin
      hex_d = wr_data;
    end else begin
      hex_d = hex_q;
    end
    if (rd_en) begin
      rd_data = switches;
    end else begin
      rd_data = 16'h0000;
    end
  end

  // Hex display register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      hex_q <= 16'h0000;
    end else begin
      hex_q <= hex_d;
    end
  end

  assign hex_reg = hex_q;

endmodule

// File: rtl/mem_access_ctrl.sv
// LC-3 memory access controller: level requests -> timed async SRAM strobes
// with WAIT_CYCLES access cycles and a four-phase Mem_Rdy handshake.
// MMIO decode at MMIO_ADDR is enabled by defining MEM_MMIO_EN.
module mem_access_ctrl
  import lc3_mem_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEF,
  parameter logic [15:0] MMIO_ADDR   = MMIO_ADDR_DEF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Mem_OE,
  input  logic        Mem_WE,
  input  logic [15:0] MAR,
  input  logic [15:0] MDR_In,
  output logic        Mem_Rdy,
  output logic [15:0] Rdata,
  output logic [19:0] SRAM_ADDR,
  output logic [15:0] SRAM_WDATA,
  output logic        SRAM_DQ_OE,
  input  logic [15:0] SRAM_RDATA,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_WE_N,
  input  logic [15:0] Switches,
  output logic [15:0] HexReg
);

  localparam int unsigned      CNT_W    = $clog2(WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  state_t           state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             is_write_d, is_write_q;
  logic [19:0]      addr_d, addr_q;
  logic [15:0]      wdata_d, wdata_q;
  logic [15:0]      rdata_d, rdata_q;
  logic             rdy_d, rdy_q;
  logic             ce_n_d, ce_n_q;
  logic             oe_n_d, oe_n_q;
  logic             we_n_d, we_n_q;
  logic             dq_oe_d, dq_oe_q;
  logic             req_s;
  logic             access_s;
  logic             mmio_hit_s;
  logic             hex_we_s;
  logic [15:0]      mmio_rdata_s;

  assign req_s = Mem_OE | Mem_WE;

`ifdef MEM_MMIO_EN
  assign mmio_hit_s = (MAR == MMIO_ADDR);

  mmio_port u_mmio_port (
    .Clk      (Clk),
    .Reset    (Reset),
    .wr_en    (hex_we_s),
    .wr_data  (MDR_In),
    .rd_en    (mmio_hit_s & ~Mem_WE),
    .switches (Switches),
    .rd_data  (mmio_rdata_s),
    .hex_reg  (HexReg)
  );
`else
  assign mmio_hit_s   = 1'b0;
  assign mmio_rdata_s = 16'h0000;
  assign HexReg       = 16'h0000;

  logic unused_s;
  assign unused_s = ^{Switches, hex_we_s};
`endif

  // FSM next state, request latching and read-data capture.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_write_d = is_write_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    hex_we_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_s) begin
          // Write wins when both requests are raised together.
          is_write_d = Mem_WE;
          addr_d     = {4'h0, MAR};
          cnt_d      = '0;
          if (Mem_WE) begin
            wdata_d = MDR_In;
          end else begin
            wdata_d = wdata_q;
          end
          if (mmio_hit_s) begin
            state_d = ST_DONE;
            if (Mem_WE) begin
              hex_we_s = 1'b1;
            end else begin
              rdata_d = mmio_rdata_s;
            end
          end else begin
            state_d = ST_ACCESS;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
          if (!is_write_q) begin
            rdata_d = SRAM_RDATA;
          end else begin
            rdata_d = rdata_q;
          end
        end else begin
          state_d = ST_ACCESS;
        end
      end
      ST_DONE: begin
        if (req_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Pin values are derived from the next state so every pin comes from a flop.
  always_comb begin
    access_s = (state_d == ST_ACCESS);
    ce_n_d   = ~access_s;
    oe_n_d   = ~(access_s & ~is_write_d);
    we_n_d   = ~(access_s & is_write_d);
    dq_oe_d  = access_s & is_write_d;
    rdy_d    = (state_d == ST_DONE);
  end

  // Controller state and registered outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      is_write_q <= 1'b0;
      addr_q     <= 20'h00000;
      wdata_q    <= 16'h0000;
      rdata_q    <= 16'h0000;
      rdy_q      <= 1'b0;
      ce_n_q     <= 1'b1;
      oe_n_q     <= 1'b1;
      we_n_q     <= 1'b1;
      dq_oe_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_write_q <= is_write_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      rdy_q      <= rdy_d;
      ce_n_q     <= ce_n_d;
      oe_n_q     <= oe_n_d;
      we_n_q     <= we_n_d;
      dq_oe_q    <= dq_oe_d;
    end
  end

  assign Mem_Rdy    = rdy_q;
  assign Rdata      = rdata_q;
  assign SRAM_ADDR  = addr_q;
  assign SRAM_WDATA = wdata_q;
  assign SRAM_DQ_OE = dq_oe_q;
  assign SRAM_CE_N  = ce_n_q;
  assign SRAM_OE_N  = oe_n_q;
  assign SRAM_WE_N  = we_n_q;

endmodule
